shifter_iter: RTL and testbench
===============================

Name: shifter_iter

Overview:
- Parametrised, multi-cycle shift unit. It generalises the existing 8-bit fixed-mode arithmetic-right shifter.
- Width is configurable and four shift modes are supported (LSL, LSR, ASR, ROR).
- The shift amount covers the full range 0..WIDTH-1 and is executed iteratively, MAX_STEP bits per cycle.
- Sits behind a valid/ready handshake on both sides, so it can feed an ALU result path or a serial datapath without a full barrel-shifter array.

Parameters:
- WIDTH, 8: data width in bits, must be >= 2.
- SHAMT_W, 3: shift-amount width, must equal clog2(WIDTH).
- MAX_STEP, 1: maximum bits shifted per cycle. Power of two, 1..WIDTH/2.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- d_in  input  WIDTH  operand.
- shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
- op  input  2  mode: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- out_valid  output  1  d_out holds a finished result.
- out_ready  input  1  consumer accepts the result.
- d_out  output  WIDTH  shifted result.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Clocking and reset:
  - One clock (clk); reset is asynchronous and active-low (reset_n).
  - Reset forces: state IDLE; out_valid 0; d_out 0; busy 0; internal data/remaining/op registers 0.
  - in_ready is 1 as soon as reset_n is low or released, because it is decoded from IDLE.
- FSM states: IDLE, SHIFT, DONE.
  - in_ready = (state==IDLE), combinational.
  - busy = (state!=IDLE).
  - out_valid = (state==DONE), registered.
- IDLE:
  - Accept when in_valid && in_ready.
  - On that edge: load data_r<=d_in, rem_r<=shamt, op_r<=op; go to SHIFT.
  - Inputs are ignored at all other times. d_in, shamt and op need only be stable in the accept cycle.
- SHIFT, each cycle:
  - step = min(rem_r, MAX_STEP).
  - data_r <= data_r shifted by step per op_r:
    - LSL fills zeros at the LSB.
    - LSR fills zeros at the MSB.
    - ASR fills copies of the original data_r[WIDTH-1]. The sign is preserved because each step replicates the current MSB.
    - ROR moves the low bits to the MSB end.
  - rem_r <= rem_r - step.
  - If rem_r==0 at cycle start: no shift; go to DONE.
- Latency:
  - out_valid rises exactly ceil(shamt/MAX_STEP)+1 cycles after the accept edge.
  - shamt=0 gives 1 cycle, with d_out = d_in.
- DONE:
  - d_out = data_r. d_out is registered and updated only on the SHIFT->DONE edge.
  - Result is held stable while out_ready is low.
  - On out_valid && out_ready: go to IDLE and drop out_valid. d_out keeps its last value.
  - No new request is accepted in the same cycle as result handoff: one operation in flight, no overlap.
- Mode behaviour is identical for every WIDTH. ROR by shamt equals a rotate modulo WIDTH.
- Boundary conditions:
  - shamt = WIDTH-1 with ASR yields all sign bits; with LSL/LSR it yields a single surviving bit.
  - in_valid held high continuously gives back-to-back operations separated only by the IDLE cycle.
- Reset mid-operation (any state): operation discarded, outputs return to reset values, no result is produced.
- X on shamt/op outside the accept cycle must not propagate.

Decomposition:
- Package shifter_pkg holds:
  - op codes OP_LSL=2'b00, OP_LSR=2'b01, OP_ASR=2'b10, OP_ROR=2'b11;
  - state encodings ST_IDLE, ST_SHIFT, ST_DONE.
- One combinational sub-module, shift_step:
  - Inputs: data, amount (0..MAX_STEP), op. Output: data shifted by amount.
  - Parametrised on WIDTH and MAX_STEP; instantiated once in the SHIFT datapath.
- The FSM, counters and handshake stay in shifter_iter.

Test Plan:
- WIDTH=8, MAX_STEP=1; d_in=0x96, shamt=3, ops LSL/LSR/ASR/ROR in turn -> d_out 0xB0 / 0x12 / 0xF2 / 0xD2; each out_valid exactly 4 cycles after accept; in_ready low throughout.
- WIDTH=8; d_in=0x5A, shamt=0, op=ASR -> out_valid 1 cycle after accept, d_out=0x5A.
- WIDTH=16, MAX_STEP=4; d_in=0x8000, shamt=15, op=ASR -> d_out=0xFFFF after 5 cycles; same operands with LSR -> 0x0001.
- Backpressure: result ready, out_ready held low 5 cycles -> out_valid and d_out stable. Then out_ready=1 -> IDLE next edge, in_ready=1, no duplicate result.
- Reset: reset_n pulsed low for 1 cycle, asynchronously (not aligned to clk), while in SHIFT with rem=4 -> out_valid=0, d_out=0, busy=0 immediately; a new request then completes correctly.
- Back-to-back: in_valid held high with 3 queued requests, out_ready=1 -> each accepted only in IDLE; results in order with correct values.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared op codes and FSM state encodings for the iterative shifter.
package shifter_pkg;

   localparam logic [1:0] OP_LSL = 2'b00;
   localparam logic [1:0] OP_LSR = 2'b01;
   localparam logic [1:0] OP_ASR = 2'b10;
   localparam logic [1:0] OP_ROR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/shifter_iter_shift_step.sv
// Combinational single step of the iterative shifter: shifts data by 0..MAX_STEP bits.
module shift_step
   import shifter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int MAX_STEP = 1,
   parameter int AMT_W    = $clog2(MAX_STEP + 1)
) (
   input  logic [WIDTH-1:0] data,
   input  logic [AMT_W-1:0] amount,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] result
);

   logic [WIDTH-1:0] lsl_c [0:MAX_STEP];
   logic [WIDTH-1:0] lsr_c [0:MAX_STEP];
   logic [WIDTH-1:0] asr_c [0:MAX_STEP];
   logic [WIDTH-1:0] ror_c [0:MAX_STEP];

   // One candidate per legal step size; the mux below picks the requested one.
   genvar gi;
   generate
      for (gi = 0; gi <= MAX_STEP; gi++) begin : g_cand
         if (gi == 0) begin : g_zero
            assign lsl_c[gi] = data;
            assign lsr_c[gi] = data;
            assign asr_c[gi] = data;
            assign ror_c[gi] = data;
         end else begin : g_nz
            assign lsl_c[gi] = {data[WIDTH-1-gi:0], {gi{1'b0}}};
            assign lsr_c[gi] = {{gi{1'b0}}, data[WIDTH-1:gi]};
            assign asr_c[gi] = {{gi{data[WIDTH-1]}}, data[WIDTH-1:gi]};
            assign ror_c[gi] = {data[gi-1:0], data[WIDTH-1:gi]};
         end
      end
   endgenerate

   always_comb begin
      result = data;
      for (int i = 0; i <= MAX_STEP; i++) begin
         if (amount == AMT_W'(i)) begin
            case (op)
               OP_LSL:  result = lsl_c[i];
               OP_LSR:  result = lsr_c[i];
               OP_ASR:  result = asr_c[i];
               default: result = ror_c[i];
            endcase
         end
      end
   end

endmodule

// File: rtl/shifter_iter.sv
// Multi-cycle shift unit (LSL/LSR/ASR/ROR) with valid/ready on both sides,
// shifting at most MAX_STEP bits per cycle.
module shifter_iter
   import shifter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int SHAMT_W  = 3,
   parameter int MAX_STEP = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   d_in,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [1:0]         op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   d_out,
   output logic               busy
);

   localparam int AMT_W = $clog2(MAX_STEP + 1);

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   data_reg;
   logic [SHAMT_W-1:0] rem_reg;
   logic [1:0]         op_reg;
   logic [WIDTH-1:0]   d_out_reg;
   logic               out_valid_reg;
   logic [AMT_W-1:0]   step;
   logic [WIDTH-1:0]   data_next;
   logic               accept;

   assign accept = in_valid && in_ready;

   always_comb begin
      if (rem_reg < SHAMT_W'(MAX_STEP)) begin
         step = AMT_W'(rem_reg);
      end else begin
         step = AMT_W'(MAX_STEP);
      end
   end

   shift_step #(
      .WIDTH    (WIDTH),
      .MAX_STEP (MAX_STEP),
      .AMT_W    (AMT_W)
   ) u_step (
      .data   (data_reg),
      .amount (step),
      .op     (op_reg),
      .result (data_next)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (accept) state_next = ST_SHIFT;
         ST_SHIFT: if (rem_reg == '0) state_next = ST_DONE;
         ST_DONE:  if (out_ready) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_reg == ST_IDLE);
      busy     = (state_reg != ST_IDLE);
   end

   // Operands are captured only on accept, so X on the inputs at other times never enters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_reg      <= '0;
         rem_reg       <= '0;
         op_reg        <= '0;
         d_out_reg     <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (accept) begin
                  data_reg <= d_in;
                  rem_reg  <= shamt;
                  op_reg   <= op;
               end
            end
            ST_SHIFT: begin
               if (rem_reg != '0) begin
                  data_reg <= data_next;
                  rem_reg  <= rem_reg - SHAMT_W'(step);
               end else begin
                  d_out_reg     <= data_reg;
                  out_valid_reg <= 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) out_valid_reg <= 1'b0;
            end
            default: out_valid_reg <= 1'b0;
         endcase
      end
   end

   assign out_valid = out_valid_reg;
   assign d_out     = d_out_reg;

endmodule

// File: tb/tb_shifter_iter.sv
// Directed bench for shifter_iter: an 8-bit/step-1 instance and a 16-bit/step-4 instance.
module tb_shifter_iter;

   logic        clk;
   logic        reset_n;

   logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
   logic [7:0]  d_in8, d_out8;
   logic [2:0]  shamt8;
   logic [1:0]  op8;

   logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
   logic [15:0] d_in16, d_out16;
   logic [3:0]  shamt16;
   logic [1:0]  op16;

   int total = 0;
   int bad   = 0;

   shifter_iter #(.WIDTH(8), .SHAMT_W(3), .MAX_STEP(1)) u8 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .d_in(d_in8), .shamt(shamt8), .op(op8), .out_valid(out_valid8),
      .out_ready(out_ready8), .d_out(d_out8), .busy(busy8)
   );

   shifter_iter #(.WIDTH(16), .SHAMT_W(4), .MAX_STEP(4)) u16 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid16), .in_ready(in_ready16),
      .d_in(d_in16), .shamt(shamt16), .op(op16), .out_valid(out_valid16),
      .out_ready(out_ready16), .d_out(d_out16), .busy(busy16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issues one request and returns at the first sample where out_valid is high (no handoff).
   task automatic run_op(input bit wide, input logic [15:0] d, input logic [3:0] sh,
                         input logic [1:0] o, output logic [15:0] res, output int lat,
                         output bit acc_ok, output bit busy_ok);
      bit got;
      if (wide) begin
         d_in16 = d; shamt16 = sh; op16 = o; in_valid16 = 1'b1;
         acc_ok = in_ready16;
      end else begin
         d_in8 = d[7:0]; shamt8 = sh[2:0]; op8 = o; in_valid8 = 1'b1;
         acc_ok = in_ready8;
      end
      @(posedge clk); #1;
      in_valid8 = 1'b0; in_valid16 = 1'b0;
      d_in8 = 'x; shamt8 = 'x; op8 = 'x;
      d_in16 = 'x; shamt16 = 'x; op16 = 'x;
      busy_ok = 1'b1;
      got = 1'b0;
      lat = 0;
      res = '0;
      while (!got && lat < 50) begin
         @(posedge clk); #1;
         lat++;
         if (wide) begin
            if (in_ready16 !== 1'b0 || busy16 !== 1'b1) busy_ok = 1'b0;
            if (out_valid16 === 1'b1) begin got = 1'b1; res = d_out16; end
         end else begin
            if (in_ready8 !== 1'b0 || busy8 !== 1'b1) busy_ok = 1'b0;
            if (out_valid8 === 1'b1) begin got = 1'b1; res = {8'h00, d_out8}; end
         end
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      in_valid8 = 1'b0; out_ready8 = 1'b1; d_in8 = '0; shamt8 = '0; op8 = '0;
      in_valid16 = 1'b0; out_ready16 = 1'b1; d_in16 = '0; shamt16 = '0; op16 = '0;
      #3;
      total++;
      if ({in_ready8, out_valid8, busy8, d_out8} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
         bad++;
         $display("FAIL reset8: rdy=%b ov=%b busy=%b dout=%h required rdy=1 ov=0 busy=0 dout=00",
                  in_ready8, out_valid8, busy8, d_out8);
      end
      total++;
      if ({in_ready16, out_valid16, busy16, d_out16} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
         bad++;
         $display("FAIL reset16: rdy=%b ov=%b busy=%b dout=%h required rdy=1 ov=0 busy=0 dout=0000",
                  in_ready16, out_valid16, busy16, d_out16);
      end
      #19 reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic check_op(input string name, input bit wide, input logic [15:0] d,
                           input logic [3:0] sh, input logic [1:0] o,
                           input logic [15:0] exp_val, input int exp_lat);
      logic [15:0] res;
      int          lat;
      bit          acc_ok, busy_ok;
      run_op(wide, d, sh, o, res, lat, acc_ok, busy_ok);
      total++;
      if (res !== exp_val) begin
         bad++;
         $display("FAIL %s value: got=%h required=%h", name, res, exp_val);
      end
      total++;
      if (lat != exp_lat) begin
         bad++;
         $display("FAIL %s latency: got=%0d required=%0d", name, lat, exp_lat);
      end
      total++;
      if (!acc_ok || !busy_ok) begin
         bad++;
         $display("FAIL %s handshake: idle_ready=%b busy_ok=%b required 1 1", name, acc_ok, busy_ok);
      end
      @(posedge clk); #1;
      total++;
      if (wide ? (in_ready16 !== 1'b1 || out_valid16 !== 1'b0)
               : (in_ready8 !== 1'b1 || out_valid8 !== 1'b0)) begin
         bad++;
         $display("FAIL %s handoff: not back in idle after out_ready", name);
      end
      $display("op %s d=%h sh=%0d -> %h lat=%0d", name, d, sh, res, lat);
   endtask

   task automatic test_modes8;
      check_op("lsl8", 1'b0, 16'h0096, 4'd3, 2'b00, 16'h00B0, 4);
      check_op("lsr8", 1'b0, 16'h0096, 4'd3, 2'b01, 16'h0012, 4);
      check_op("asr8", 1'b0, 16'h0096, 4'd3, 2'b10, 16'h00F2, 4);
      check_op("ror8", 1'b0, 16'h0096, 4'd3, 2'b11, 16'h00D2, 4);
      check_op("asr8_max", 1'b0, 16'h0080, 4'd7, 2'b10, 16'h00FF, 8);
   endtask

   task automatic test_zero_shift;
      check_op("zero8", 1'b0, 16'h005A, 4'd0, 2'b10, 16'h005A, 1);
   endtask

   task automatic test_wide;
      check_op("asr16", 1'b1, 16'h8000, 4'd15, 2'b10, 16'hFFFF, 5);
      check_op("lsr16", 1'b1, 16'h8000, 4'd15, 2'b01, 16'h0001, 5);
      check_op("lsl16", 1'b1, 16'h0001, 4'd15, 2'b00, 16'h8000, 5);
      check_op("ror16", 1'b1, 16'h1234, 4'd6,  2'b11, 16'hD048, 3);
   endtask

   task automatic test_backpressure;
      logic [15:0] res;
      int          lat;
      bit          acc_ok, busy_ok;
      out_ready8 = 1'b0;
      run_op(1'b0, 16'h00C3, 4'd1, 2'b11, res, lat, acc_ok, busy_ok);
      total++;
      if (res !== 16'h00E1 || lat != 2) begin
         bad++;
         $display("FAIL bp_result: got=%h lat=%0d required=00e1 lat=2", res, lat);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         total++;
         if (out_valid8 !== 1'b1 || d_out8 !== 8'hE1 || in_ready8 !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold%0d: ov=%b dout=%h rdy=%b required ov=1 dout=e1 rdy=0",
                     i, out_valid8, d_out8, in_ready8);
         end
      end
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      total++;
      if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || d_out8 !== 8'hE1) begin
         bad++;
         $display("FAIL bp_release: ov=%b rdy=%b dout=%h required ov=0 rdy=1 dout=e1",
                  out_valid8, in_ready8, d_out8);
      end
      @(posedge clk); #1;
      total++;
      if (out_valid8 !== 1'b0) begin
         bad++;
         $display("FAIL bp_dup: ov=%b required 0", out_valid8);
      end
      $display("op backpressure result=%h held 5 cycles", res);
   endtask

   task automatic test_mid_reset;
      bit seen;
      out_ready8 = 1'b1;
      d_in8 = 8'h81; shamt8 = 3'd7; op8 = 2'b01; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (busy8 !== 1'b1) begin
         bad++;
         $display("FAIL midrst_busy: busy=%b required 1", busy8);
      end
      #3 reset_n = 1'b0;
      #1;
      total++;
      if ({out_valid8, d_out8, busy8, in_ready8} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL midrst_async: ov=%b dout=%h busy=%b rdy=%b required 0 00 0 1",
                  out_valid8, d_out8, busy8, in_ready8);
      end
      #9 reset_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid8 !== 1'b0 || busy8 !== 1'b0) seen = 1'b1;
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL midrst_ghost: activity after reset with no request");
      end
      $display("op mid-reset discarded");
      check_op("after_rst", 1'b0, 16'h0081, 4'd7, 2'b01, 16'h0001, 8);
   endtask

   task automatic test_back_to_back;
      logic [7:0] rd   [0:2] = '{8'h96, 8'h96, 8'h3C};
      logic [2:0] rs   [0:2] = '{3'd1, 3'd2, 3'd5};
      logic [1:0] ro   [0:2] = '{2'b00, 2'b10, 2'b11};
      logic [7:0] rexp [0:2] = '{8'h2C, 8'hE5, 8'hE1};
      int         redge [0:2] = '{3, 8, 16};
      int         idx, nres;
      bit         acc;
      out_ready8 = 1'b1;
      idx = 0; nres = 0;
      d_in8 = rd[0]; shamt8 = rs[0]; op8 = ro[0]; in_valid8 = 1'b1;
      for (int cyc = 1; cyc <= 60 && nres < 3; cyc++) begin
         acc = in_valid8 && in_ready8;
         @(posedge clk); #1;
         if (acc) begin
            idx++;
            if (idx < 3) begin
               d_in8 = rd[idx]; shamt8 = rs[idx]; op8 = ro[idx];
            end else begin
               in_valid8 = 1'b0;
            end
         end
         if (out_valid8 === 1'b1) begin
            total++;
            if (d_out8 !== rexp[nres] || cyc != redge[nres] || in_ready8 !== 1'b0) begin
               bad++;
               $display("FAIL b2b%0d: dout=%h edge=%0d rdy=%b required dout=%h edge=%0d rdy=0",
                        nres, d_out8, cyc, in_ready8, rexp[nres], redge[nres]);
            end
            $display("op b2b%0d result=%h at edge %0d", nres, d_out8, cyc);
            nres++;
         end
      end
      total++;
      if (nres != 3) begin
         bad++;
         $display("FAIL b2b_count: got=%0d required=3", nres);
      end
      in_valid8 = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_modes8();
      test_zero_shift();
      test_wide();
      test_backpressure();
      test_mid_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
